// File: rtl/demux_pkg.sv
// Shared constants and helpers for the 1-to-4 demultiplexer.
package demux_pkg;

  localparam int NUM_OUT    = 4;
  localparam int SEL_W      = 2;
  localparam int FIFO_DEPTH = 2;
  localparam int CNT_W      = 8;
  localparam int OCC_W      = $clog2(FIFO_DEPTH + 1);

  // One-hot decode of a channel select.
  function automatic logic [NUM_OUT-1:0] sel_decode(input logic [SEL_W-1:0] sel);
    sel_decode = NUM_OUT'(1) << sel;
  endfunction

endpackage

// File: rtl/demux_fifo2.sv
// Two-entry FIFO used as the per-channel buffer. Push into a full FIFO
// and pop from an empty FIFO are ignored, so callers need not pre-gate.
module demux_fifo2
  import demux_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             empty
);

  logic [FIFO_DEPTH-1:0][WIDTH-1:0] mem;
  logic [OCC_W-1:0]                 occ;
  logic                             rd_ptr;
  logic                             wr_ptr;
  logic                             do_push;
  logic                             do_pop;

  assign full      = (occ == OCC_W'(FIFO_DEPTH));
  assign empty     = (occ == '0);
  assign do_push   = push & ~full;
  assign do_pop    = pop & ~empty;
  assign head_data = mem[rd_ptr];

  // Occupancy and pointer bookkeeping; both pointers wrap 1 -> 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ    <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  // Storage is left uninitialised; a reset only empties the FIFO.
  always_ff @(posedge clk) begin
    if (do_push && !rst) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/demux_1x4.sv
// Routes one input stream into four buffered output channels by select.
module demux_1x4
  import demux_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SEL_W-1:0]   in_select,
  output logic               in_ready,
  output logic [NUM_OUT-1:0] out_valid,
  output logic [WIDTH-1:0]   out_data0,
  output logic [WIDTH-1:0]   out_data1,
  output logic [WIDTH-1:0]   out_data2,
  output logic [WIDTH-1:0]   out_data3,
  input  logic [NUM_OUT-1:0] out_ready,
  output logic [CNT_W-1:0]   out_count0,
  output logic [CNT_W-1:0]   out_count1,
  output logic [CNT_W-1:0]   out_count2,
  output logic [CNT_W-1:0]   out_count3
);

  logic [NUM_OUT-1:0]            full;
  logic [NUM_OUT-1:0]            empty;
  logic [NUM_OUT-1:0]            push;
  logic [NUM_OUT-1:0]            pop;
  logic [NUM_OUT-1:0][WIDTH-1:0] head;
  logic [NUM_OUT-1:0][CNT_W-1:0] cnt;
  logic                          in_xfer;

  // Ready comes from registered FIFO state only, so it never loops back
  // through out_ready or in_valid.
  assign in_ready  = ~full[in_select];
  assign in_xfer   = in_valid & in_ready & ~rst;
  assign push      = in_xfer ? sel_decode(in_select) : '0;
  assign pop       = out_ready & ~empty;
  assign out_valid = ~empty;

  assign out_data0  = head[0];
  assign out_data1  = head[1];
  assign out_data2  = head[2];
  assign out_data3  = head[3];
  assign out_count0 = cnt[0];
  assign out_count1 = cnt[1];
  assign out_count2 = cnt[2];
  assign out_count3 = cnt[3];

  for (genvar g = 0; g < NUM_OUT; g++) begin : g_ch
    demux_fifo2 #(.WIDTH(WIDTH)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push[g]),
      .push_data (in_data),
      .full      (full[g]),
      .pop       (pop[g]),
      .head_data (head[g]),
      .empty     (empty[g])
    );

    // Accepted-word counter per channel, wrapping 255 -> 0.
    always_ff @(posedge clk) begin
      if (rst)          cnt[g] <= '0;
      else if (push[g]) cnt[g] <= cnt[g] + 1'b1;
    end
  end

endmodule

// File: doc/demux_1x4.md
DEMUX_1X4 -- requirements
Module: demux_1x4

Interface
REQ-001 Parameter WIDTH SHALL default to 32 and set the data width of the input and all four outputs.
REQ-002 clk, input, 1: single clock; all state updates on the rising edge.
REQ-003 rst, input, 1: reset, synchronous and active-high.
REQ-004 in_valid, input, 1: the source presents a word.
REQ-005 in_data, input, WIDTH: the word to route.
REQ-006 in_select, input, 2: destination channel, 0 to 3.
REQ-007 in_ready, output, 1: the block accepts the word this cycle.
REQ-008 out_valid, output, 4: bit k is high when channel k holds a word.
REQ-009 out_data0 / out_data1 / out_data2 / out_data3, output, WIDTH each: head word of each channel.
REQ-010 out_ready, input, 4: bit k is high when the sink of channel k takes its head word.
REQ-011 out_count0 / out_count1 / out_count2 / out_count3, output, 8 each: words accepted into each channel since reset.

Function
REQ-012 An input transfer SHALL occur on a rising edge where in_valid=1 and in_ready=1.
REQ-013 An output transfer on channel k SHALL occur on a rising edge where out_valid[k]=1 and out_ready[k]=1.
REQ-014 Each channel SHALL own a 2-entry FIFO; words leave it in the order they arrived.
REQ-015 in_ready SHALL be 1 when the FIFO of channel in_select is not full, and 0 when it is full.
REQ-016 in_ready SHALL depend only on registered FIFO state and in_select; it SHALL NOT depend on out_ready or in_valid.
REQ-017 Latency SHALL be 1 cycle: a word accepted at edge N drives out_valid[sel]=1 and out_dataSEL=in_data after edge N, when that FIFO was empty.
REQ-018 out_valid[k] SHALL equal "FIFO k not empty".
REQ-019 out_dataK SHALL show the FIFO head while valid; its value while not valid is don't-care.
REQ-020 Push and pop on the same channel in the same edge SHALL both happen, and the occupancy SHALL stay the same.
REQ-021 A push to a full channel SHALL NOT happen, even when that channel pops in the same edge; the source retries next cycle.
REQ-022 Pops on channels other than the one being pushed SHALL proceed independently in the same cycle.
REQ-023 While in_valid=1 and in_ready=0, the source SHALL hold in_data and in_select stable; the block's behaviour otherwise is undefined.
REQ-024 A channel that is full SHALL NOT block pushes to any other channel.
REQ-025 out_countK SHALL increment by 1 on each input transfer to channel k and wrap 255 -> 0.
REQ-026 A pop on an empty FIFO SHALL NOT happen; out_ready[k] is ignored while out_valid[k]=0.
REQ-027 Per-channel state SHALL be an occupancy count (0, 1 or 2) plus read and write pointers that wrap 1 -> 0.

Reset
REQ-028 With rst=1 at an edge, all FIFOs SHALL become empty; out_valid=4'b0000 and all out_countK=0.
REQ-029 in_ready SHALL be 1 from the first cycle after reset, whatever in_select is.
REQ-030 Reset in the middle of operation SHALL discard every stored word, and no input transfer SHALL occur on an edge where rst=1.
REQ-031 Data storage registers MAY stay uninitialised on reset.

Structure
REQ-032 The shared package demux_pkg SHALL hold NUM_OUT=4, SEL_W=2, FIFO_DEPTH=2 and CNT_W=8.
REQ-033 The per-channel FIFO SHALL be the sub-module demux_fifo2, instantiated 4 times.
REQ-034 demux_fifo2 SHALL have ports: push, push_data, full, pop, head_data, empty.
REQ-035 The top level SHALL contain only select decode, in_ready generation and the per-channel counters.

Verification
REQ-036 Reset then single words: after rst, push 0x11111111 to sel 0, 0x22222222 to sel 1, 0x33333333 to sel 2, 0x44444444 to sel 3, with out_ready=4'b1111 -> each out_dataK matches 1 cycle after acceptance, and out_countK=1 each.
REQ-037 Backpressure full: out_ready[2]=0, push 0xA, 0xB, 0xC to sel 2 -> in_ready=0 on the 3rd try; raise out_ready[2] -> 0xA then 0xB then 0xC in order, and out_count2=3.
REQ-038 Full channel isolation: channel 1 full with out_ready[1]=0, push 0x5 to sel 3 -> accepted at once, and out_valid=4'b1010.
REQ-039 Simultaneous push and pop: channel 0 holds 1 word, out_ready[0]=1, push 0x77 to sel 0 -> occupancy stays 1, the old head leaves, and 0x77 is the next head.
REQ-040 Counter wrap: 256 transfers to sel 3 -> out_count3 reads 255 after the 255th transfer and 0 after the 256th.
REQ-041 Reset mid-stream: channels 0 and 2 full, assert rst for 1 cycle while in_valid=1 -> out_valid=0, counts=0, in_ready=1, and no stale word appears afterwards.
